// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// Data wins ties; a grant-streak counter forces a fetch grant after MAX_DATA_BURST data grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [3:0] MaxBurst = 4'(MAX_DATA_BURST);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyD} state_e;

  state_e     state_q;
  logic [3:0] streak_q;
  logic       pick_d;

  // Data wins unless a fetch is waiting and the data streak has hit its limit.
  assign pick_d = d_req && !(if_req && (streak_q == MaxBurst));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      streak_q  <= '0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (d_req || if_req) begin
            mem_req <= 1'b1;
            if (pick_d) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_wstrb <= d_wstrb;
              d_gnt     <= 1'b1;
              state_q   <= StBusyD;
              if (!if_req) begin
                streak_q <= '0;
              end else if (streak_q != MaxBurst) begin
                streak_q <= streak_q + 4'd1;
              end
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_wstrb <= '0;
              if_gnt    <= 1'b1;
              state_q   <= StBusyIf;
              streak_q  <= '0;
            end
          end
        end
        StBusyIf, StBusyD: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state_q <= StIdle;
            if (state_q == StBusyD) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; outputs sampled 1 time unit after each
// rising edge, inputs changed at the same point so they are stable for the next edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_DATA_BURST(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_wstrb(d_wstrb),
    .d_gnt(d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] got_d;
    logic [9:0] exp_d;
    int         n;

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_d_gnt", 32'(d_gnt), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    rst_n = 1'b1;
    step();

    // Single fetch, ack three cycles after mem_req rises
    if_req = 1'b1; if_addr = 32'h100;
    step();
    check("f_if_gnt", 32'(if_gnt), 32'd1);
    check("f_d_gnt", 32'(d_gnt), 32'd0);
    check("f_mem_req", 32'(mem_req), 32'd1);
    check("f_mem_addr", mem_addr, 32'h100);
    check("f_mem_we", 32'(mem_we), 32'd0);
    check("f_mem_wstrb", 32'(mem_wstrb), 32'd0);
    if_req = 1'b0;
    step();
    check("f_gnt_pulse", 32'(if_gnt), 32'd0);
    check("f_req_held", 32'(mem_req), 32'd1);
    step();
    check("f_req_held2", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    step();
    check("f_rvalid", 32'(if_rvalid), 32'd1);
    check("f_rdata", if_rdata, 32'h0050_0093);
    check("f_req_drop", 32'(mem_req), 32'd0);
    check("f_no_d_rvalid", 32'(d_rvalid), 32'd0);
    mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    step();
    check("f_rvalid_pulse", 32'(if_rvalid), 32'd0);
    check("f_rdata_hold", if_rdata, 32'h0050_0093);

    // Store with zero-wait memory
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    mem_ack = 1'b1; mem_rdata = 32'h0;
    step();
    check("s_d_gnt", 32'(d_gnt), 32'd1);
    check("s_if_gnt", 32'(if_gnt), 32'd0);
    check("s_mem_req", 32'(mem_req), 32'd1);
    check("s_mem_we", 32'(mem_we), 32'd1);
    check("s_mem_addr", mem_addr, 32'h2000);
    check("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("s_mem_wstrb", 32'(mem_wstrb), 32'h3);
    d_req = 1'b0; d_we = 1'b0;
    step();
    check("s_mem_req_drop", 32'(mem_req), 32'd0);
    check("s_d_rvalid", 32'(d_rvalid), 32'd1);
    check("s_no_if_rvalid", 32'(if_rvalid), 32'd0);
    mem_ack = 1'b0;
    step();
    check("s_d_rvalid_pulse", 32'(d_rvalid), 32'd0);
    check("s_idle", 32'(mem_req), 32'd0);

    // Simultaneous requests: data first, fetch at the next idle edge
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    step();
    check("b_d_gnt", 32'(d_gnt), 32'd1);
    check("b_if_gnt", 32'(if_gnt), 32'd0);
    check("b_mem_addr", mem_addr, 32'h3000);
    check("b_mem_we", 32'(mem_we), 32'd0);
    d_req = 1'b0;
    step();
    check("b_d_rvalid", 32'(d_rvalid), 32'd1);
    check("b_d_rdata", d_rdata, 32'h1122_3344);
    check("b_if_gnt_busy", 32'(if_gnt), 32'd0);
    mem_rdata = 32'h0000_0055;
    step();
    check("b_if_gnt2", 32'(if_gnt), 32'd1);
    check("b_mem_addr2", mem_addr, 32'h104);
    if_req = 1'b0;
    step();
    check("b_if_rvalid", 32'(if_rvalid), 32'd1);
    check("b_if_rdata", if_rdata, 32'h55);
    check("b_d_rdata_hold", d_rdata, 32'h1122_3344);

    // Starvation guard: both requests held, zero-wait memory
    d_req = 1'b1; if_req = 1'b1; mem_ack = 1'b1;
    got_d = '0; n = 0;
    exp_d = 10'b01111_01111;
    for (int i = 0; i < 20; i++) begin
      step();
      if (d_gnt && n < 10) begin got_d[n] = 1'b1; n++; end
      if (if_gnt && n < 10) begin got_d[n] = 1'b0; n++; end
    end
    d_req = 1'b0; if_req = 1'b0;
    check("st_grant_count", 32'(n), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("st_grant_%0d_is_d", i), 32'(got_d[i]), 32'(exp_d[i]));
    end
    step();
    mem_ack = 1'b0;
    step();
    check("st_idle", 32'(mem_req), 32'd0);

    // Spurious ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    step();
    check("sp_if_rvalid", 32'(if_rvalid), 32'd0);
    check("sp_d_rvalid", 32'(d_rvalid), 32'd0);
    check("sp_mem_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    if_req = 1'b1; if_addr = 32'h200;
    step();
    check("sp_if_gnt", 32'(if_gnt), 32'd1);
    check("sp_mem_addr", mem_addr, 32'h200);
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_ABCD;
    step();
    check("sp_if_rvalid2", 32'(if_rvalid), 32'd1);
    check("sp_if_rdata", if_rdata, 32'hABCD);
    mem_ack = 1'b0;
    step();

    // Asynchronous reset in the middle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4000; d_wdata = 32'h1234; d_wstrb = 4'hF;
    step();
    check("r_d_gnt", 32'(d_gnt), 32'd1);
    d_req = 1'b0;
    step();
    check("r_busy", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("r_mem_req", 32'(mem_req), 32'd0);
    check("r_mem_we", 32'(mem_we), 32'd0);
    check("r_mem_addr", mem_addr, 32'd0);
    check("r_mem_wdata", mem_wdata, 32'd0);
    check("r_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("r_if_rdata", if_rdata, 32'd0);
    check("r_d_rdata", d_rdata, 32'd0);
    mem_ack = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    check("r_no_d_rvalid", 32'(d_rvalid), 32'd0);
    check("r_no_mem_req", 32'(mem_req), 32'd0);
    step();
    check("r_no_d_rvalid2", 32'(d_rvalid), 32'd0);
    check("r_no_if_rvalid", 32'(if_rvalid), 32'd0);
    mem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
